// File: rtl/cg_iteration_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : cg_iteration_sequencer
// Description : Iteration FSM for the complex (Bi)CG solver datapath. It issues
//               stage starts and read beats, checks convergence and counts
//               iterations. Define CG_SEQ_CYCLE_COUNT_EN to build the busy-cycle
//               counter.
// Revision    : 1.0 - initial release
// =============================================================================
module cg_iteration_sequencer #(
    parameter int         NUM_EQ    = 10,
    parameter int         NUM_LANES = 8,
    parameter int         ITER_W    = 16,
    parameter logic [7:0] BEAT_MASK = 8'b0010_0001,
    parameter int         CYC_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              abort,
    input  logic [31:0]       tol,
    input  logic [ITER_W-1:0] max_iter,
    input  logic [7:0]        stage_done,
    input  logic [31:0]       rnorm_re,
    output logic [7:0]        stage_start,
    output logic              read_beat,
    output logic [31:0]       beat_addr,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              timeout,
    output logic              aborted,
    output logic [ITER_W-1:0] iter_count,
    output logic [2:0]        fsm_state,
    output logic [CYC_W-1:0]  cycle_count
);

    localparam int          NUM_BEATS = (NUM_EQ + NUM_LANES - 1) / NUM_LANES;
    localparam logic [31:0] LAST_BEAT = 32'(NUM_BEATS - 1);
    localparam logic [2:0]  STG_RNORM = 3'd5;
    localparam logic [2:0]  STG_BETA  = 3'd6;
    localparam logic [2:0]  STG_UPDP  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_BEATS  = 3'd2,
        S_WAIT   = 3'd3,
        S_CHECK  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t            state_q;
    logic [2:0]        cur_q;
    logic              sticky_q;
    logic [31:0]       rnorm_q;
    logic [ITER_W-1:0] iter_q;
    logic [7:0]        stage_start_q;
    logic              read_beat_q;
    logic [31:0]       beat_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              converged_q;
    logic              timeout_q;
    logic              aborted_q;

    logic [ITER_W-1:0] iter_d;
    logic [ITER_W-1:0] max_iter_d;
    logic              stage_hit_d;
    logic              conv_d;
    logic [2:0]        next_stage_d;

    assign iter_d       = iter_q + {{(ITER_W-1){1'b0}}, 1'b1};
    assign max_iter_d   = (max_iter == '0) ? {{(ITER_W-1){1'b0}}, 1'b1} : max_iter;
    assign stage_hit_d  = stage_done[cur_q] | sticky_q;
    // Unsigned compare orders non-negative floats; a set sign bit never converges.
    assign conv_d       = (rnorm_q <= tol);
    assign next_stage_d = (cur_q == STG_UPDP) ? 3'd1 : cur_q + 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cur_q         <= 3'd0;
            sticky_q      <= 1'b0;
            rnorm_q       <= 32'd0;
            iter_q        <= '0;
            stage_start_q <= 8'd0;
            read_beat_q   <= 1'b0;
            beat_addr_q   <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            converged_q   <= 1'b0;
            timeout_q     <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            stage_start_q <= 8'd0;
            read_beat_q   <= 1'b0;
            beat_addr_q   <= 32'd0;
            done_q        <= 1'b0;

            if (state_q != S_IDLE && abort) begin
                state_q  <= S_IDLE;
                busy_q   <= 1'b0;
                sticky_q <= 1'b0;
                aborted_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (go) begin
                            converged_q   <= 1'b0;
                            timeout_q     <= 1'b0;
                            aborted_q     <= 1'b0;
                            iter_q        <= '0;
                            cur_q         <= 3'd0;
                            sticky_q      <= 1'b0;
                            busy_q        <= 1'b1;
                            stage_start_q <= 8'd1;
                            state_q       <= S_ISSUE;
                        end
                    end

                    S_ISSUE: begin
                        sticky_q <= 1'b0;
                        if (BEAT_MASK[cur_q]) begin
                            read_beat_q <= 1'b1;
                            beat_addr_q <= 32'd0;
                            state_q     <= S_BEATS;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end

                    S_BEATS: begin
                        // A finish that beats the read burst is remembered for WAIT.
                        if (stage_done[cur_q]) begin
                            sticky_q <= 1'b1;
                        end
                        if (cur_q == STG_RNORM && stage_done[STG_RNORM]) begin
                            rnorm_q <= rnorm_re;
                        end
                        if (beat_addr_q == LAST_BEAT) begin
                            state_q <= S_WAIT;
                        end else begin
                            read_beat_q <= 1'b1;
                            beat_addr_q <= beat_addr_q + 32'd1;
                        end
                    end

                    S_WAIT: begin
                        if (stage_hit_d) begin
                            sticky_q <= 1'b0;
                            if (cur_q == STG_RNORM) begin
                                if (stage_done[STG_RNORM]) begin
                                    rnorm_q <= rnorm_re;
                                end
                                state_q <= S_CHECK;
                            end else begin
                                cur_q         <= next_stage_d;
                                stage_start_q <= 8'd1 << next_stage_d;
                                state_q       <= S_ISSUE;
                            end
                        end
                    end

                    S_CHECK: begin
                        iter_q <= iter_d;
                        if (conv_d) begin
                            converged_q <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= S_FINISH;
                        end else if (iter_d >= max_iter_d) begin
                            timeout_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= S_FINISH;
                        end else begin
                            // Later iterations reuse rho from RNORM and resume at BETA.
                            cur_q         <= STG_BETA;
                            stage_start_q <= 8'd1 << STG_BETA;
                            state_q       <= S_ISSUE;
                        end
                    end

                    S_FINISH: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end

                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CG_SEQ_CYCLE_COUNT_EN
    logic [CYC_W-1:0] cycle_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (go) begin
                cycle_q <= '0;
            end
        end else if (cycle_q != '1) begin
            cycle_q <= cycle_q + {{(CYC_W-1){1'b0}}, 1'b1};
        end
    end

    assign cycle_count = cycle_q;
`else
    assign cycle_count = '0;
`endif

    assign stage_start = stage_start_q;
    assign read_beat   = read_beat_q;
    assign beat_addr   = beat_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = converged_q;
    assign timeout     = timeout_q;
    assign aborted     = aborted_q;
    assign iter_count  = iter_q;
    assign fsm_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cg_iteration_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : tb_cg_iteration_sequencer
// Description : Directed bench with a trace-level model of the iteration
//               sequencer; CG_SEQ_CYCLE_COUNT_EN selects the counter check.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_cg_iteration_sequencer;

    localparam int         NEQ   = 10;
    localparam int         NLN   = 8;
    localparam int         IW    = 16;
    localparam int         CW    = 32;
    localparam int         NB    = 2;
    localparam logic [7:0] BMASK = 8'b0010_0001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   tol = 32'd0;
    logic [IW-1:0] max_iter = '0;
    logic [7:0]    stage_done = 8'd0;
    logic [31:0]   rnorm_re = 32'hFFFF_FFFF;
    logic [7:0]    stage_start;
    logic          read_beat;
    logic [31:0]   beat_addr;
    logic          busy;
    logic          done;
    logic          converged;
    logic          timeout;
    logic          aborted;
    logic [IW-1:0] iter_count;
    logic [2:0]    fsm_state;
    logic [CW-1:0] cycle_count;

    cg_iteration_sequencer #(
        .NUM_EQ    (NEQ),
        .NUM_LANES (NLN),
        .ITER_W    (IW),
        .BEAT_MASK (BMASK),
        .CYC_W     (CW)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .abort       (abort),
        .tol         (tol),
        .max_iter    (max_iter),
        .stage_done  (stage_done),
        .rnorm_re    (rnorm_re),
        .stage_start (stage_start),
        .read_beat   (read_beat),
        .beat_addr   (beat_addr),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .timeout     (timeout),
        .aborted     (aborted),
        .iter_count  (iter_count),
        .fsm_state   (fsm_state),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] st;
        logic       rd;
        int         ad;
        logic       bz;
        logic       dn;
        logic [2:0] fs;
    } exp_t;

    exp_t exp_q[$];
    exp_t cmp_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_idx = 0;
    bit   chk_en = 1'b0;
    int   off[8];
    int   exp_cyc, exp_iter, n_s0, n_done, n_trace;
    bit   exp_conv, exp_tmo, exp_ab;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    // Expected per-cycle output trace, built segment by segment from the stage rules.
    function automatic void push(logic [7:0] st, logic rd, int ad, logic bz, logic dn, logic [2:0] fs);
        exp_t e;
        e.st = st; e.rd = rd; e.ad = ad; e.bz = bz; e.dn = dn; e.fs = fs;
        exp_q.push_back(e);
        if (bz) exp_cyc++;
    endfunction

    function automatic bit model_stage(int s, int ab);
        int nb;
        int w;
        nb = BMASK[s] ? NB : 0;
        push(8'(1 << s), 1'b0, 0, 1'b1, 1'b0, 3'd1);
        if (s == ab) begin
            push(8'd0, 1'b0, 0, 1'b1, 1'b0, 3'd3);
            return 1'b1;
        end
        for (int b = 0; b < nb; b++) push(8'd0, 1'b1, b, 1'b1, 1'b0, 3'd2);
        w = (off[s] <= nb) ? 1 : off[s] - nb;
        for (int k = 0; k < w; k++) push(8'd0, 1'b0, 0, 1'b1, 1'b0, 3'd3);
        return 1'b0;
    endfunction

    function automatic void build_trace(logic [31:0] rn, logic [31:0] tl, logic [IW-1:0] mi, int ab);
        int it;
        int mie;
        bit stop;
        exp_q.delete();
        exp_cyc = 0; exp_conv = 0; exp_tmo = 0; it = 0;
        mie  = (mi == 0) ? 1 : int'(mi);
        stop = model_stage(0, ab);
        while (!stop) begin
            for (int s = 1; s <= 5 && !stop; s++) stop = model_stage(s, ab);
            if (stop) break;
            push(8'd0, 1'b0, 0, 1'b1, 1'b0, 3'd4);
            it++;
            if (rn <= tl) begin exp_conv = 1; break; end
            if (it >= mie) begin exp_tmo = 1; break; end
            stop = model_stage(6, ab);
            if (!stop) stop = model_stage(7, ab);
        end
        if (!stop) push(8'd0, 1'b0, 0, 1'b1, 1'b1, 3'd5);
        push(8'd0, 1'b0, 0, 1'b0, 1'b0, 3'd0);
        exp_iter = it;
        exp_ab   = stop;
    endfunction

    always @(negedge clk) begin
        if (chk_en && exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            chk($sformatf("c%0d.stage_start", cyc_idx), {24'd0, stage_start}, {24'd0, cmp_e.st});
            chk($sformatf("c%0d.read_beat", cyc_idx), {31'd0, read_beat}, {31'd0, cmp_e.rd});
            chk($sformatf("c%0d.beat_addr", cyc_idx), beat_addr, 32'(cmp_e.ad));
            chk($sformatf("c%0d.busy", cyc_idx), {31'd0, busy}, {31'd0, cmp_e.bz});
            chk($sformatf("c%0d.done", cyc_idx), {31'd0, done}, {31'd0, cmp_e.dn});
            chk($sformatf("c%0d.fsm_state", cyc_idx), {29'd0, fsm_state}, {29'd0, cmp_e.fs});
            cyc_idx++;
        end
    end

    function automatic void default_off();
        for (int s = 0; s < 8; s++) off[s] = 1 + (BMASK[s] ? NB : 0) + 2;
    endfunction

    // Sub-unit responder: stage s finishes off[s] cycles after its start pulse.
    task automatic run_solve(input logic [31:0] rn, input logic [31:0] tl, input logic [IW-1:0] mi,
                             input int ab, input bit gof);
        int  s;
        int  cnt;
        bit  pend;
        bit  ab_arm;
        build_trace(rn, tl, mi, ab);
        n_trace = exp_q.size();
        tol = tl; max_iter = mi;
        n_s0 = 0; n_done = 0; pend = 0; ab_arm = 0; s = 0; cnt = 0;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < n_trace; i++) begin
            @(negedge clk);
            stage_done = 8'd0; abort = 1'b0; go = 1'b0; rnorm_re = 32'hFFFF_FFFF;
            if (i == 0) begin
                chk("go.iter_cleared", {16'd0, iter_count}, 32'd0);
                chk("go.flags_cleared", {29'd0, converged, timeout, aborted}, 32'd0);
                chk("go.cycle_cleared", cycle_count, 32'd0);
            end
            if (ab_arm) begin
                abort = 1'b1;
                stage_done[ab] = 1'b1;
                ab_arm = 0;
            end else if (pend) begin
                cnt++;
                if (cnt == off[s]) begin
                    stage_done[s] = 1'b1;
                    if (s == 5) rnorm_re = rn;
                    pend = 0;
                end
            end
            if (done) begin
                n_done++;
                if (gof) go = 1'b1;
            end
            if (stage_start != 8'd0) begin
                for (int k = 7; k >= 0; k--) if (stage_start[k]) s = k;
                if (s == 0) n_s0++;
                if (s == ab) ab_arm = 1;
                else begin pend = 1; cnt = 0; end
            end
        end
        @(posedge clk);
        #1 chk_en = 1'b0;
        stage_done = 8'd0; go = 1'b0; abort = 1'b0;
    endtask

    task automatic check_end(input string tag);
        chk({tag, ".converged"}, {31'd0, converged}, {31'd0, exp_conv});
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, exp_tmo});
        chk({tag, ".aborted"}, {31'd0, aborted}, {31'd0, exp_ab});
        chk({tag, ".iter_count"}, {16'd0, iter_count}, 32'(exp_iter));
        chk({tag, ".done_pulses"}, 32'(n_done), exp_ab ? 32'd0 : 32'd1);
`ifdef CG_SEQ_CYCLE_COUNT_EN
        chk({tag, ".cycle_count"}, cycle_count, 32'(exp_cyc));
`else
        chk({tag, ".cycle_count"}, cycle_count, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 8; k++) off[k] = 0;
        repeat (3) @(negedge clk);
        chk("rst.stage_start", {24'd0, stage_start}, 32'd0);
        chk("rst.read_beat", {31'd0, read_beat}, 32'd0);
        chk("rst.beat_addr", beat_addr, 32'd0);
        chk("rst.busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst.flags", {29'd0, converged, timeout, aborted}, 32'd0);
        chk("rst.iter_count", {16'd0, iter_count}, 32'd0);
        chk("rst.fsm_state", {29'd0, fsm_state}, 32'd0);
        chk("rst.cycle_count", cycle_count, 32'd0);
        reset = 1'b0;

        default_off();
        run_solve(32'h3A00_0000, 32'h3C23_D70A, 16'd5, -1, 1'b0);
        chk("conv.trace_len", 32'(n_trace), 32'd31);
        chk("conv.model_busy", 32'(exp_cyc), 32'd30);
        chk("conv.converged_lit", {31'd0, converged}, 32'd1);
        chk("conv.iter_lit", {16'd0, iter_count}, 32'd1);
        check_end("conv");

        run_solve(32'h3F80_0000, 32'h3A83_126F, 16'd3, -1, 1'b0);
        chk("tmo.model_busy", 32'(exp_cyc), 32'd92);
        chk("tmo.timeout_lit", {31'd0, timeout}, 32'd1);
        chk("tmo.iter_lit", {16'd0, iter_count}, 32'd3);
        chk("tmo.stage0_once", 32'(n_s0), 32'd1);
        check_end("tmo");

        off[0] = 1;
        off[5] = 2;
        run_solve(32'h3C23_D70A, 32'h3C23_D70A, 16'd5, -1, 1'b0);
        chk("early.model_busy", 32'(exp_cyc), 32'd26);
        chk("early.converged_lit", {31'd0, converged}, 32'd1);
        check_end("early");

        default_off();
        run_solve(32'h3F80_0000, 32'h3A83_126F, 16'd0, -1, 1'b0);
        chk("max0.iter_lit", {16'd0, iter_count}, 32'd1);
        check_end("max0");

        run_solve(32'h8000_0001, 32'h7F80_0000, 16'd2, -1, 1'b1);
        chk("neg.timeout_lit", {31'd0, timeout}, 32'd1);
        check_end("neg");

        run_solve(32'h3A00_0000, 32'h3C23_D70A, 16'd5, 2, 1'b0);
        chk("abort.model_busy", 32'(exp_cyc), 32'd12);
        chk("abort.aborted_lit", {31'd0, aborted}, 32'd1);
        check_end("abort");

        run_solve(32'h3A00_0000, 32'h3C23_D70A, 16'd5, -1, 1'b0);
        check_end("restart");

        // Asynchronous reset while read beats are in flight.
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        chk("rstmid.issue_start", {24'd0, stage_start}, 32'd1);
        @(posedge clk);
        #1;
        chk("rstmid.in_beats", {29'd0, fsm_state}, 32'd2);
        chk("rstmid.read_beat_on", {31'd0, read_beat}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid.read_beat", {31'd0, read_beat}, 32'd0);
        chk("rstmid.busy", {31'd0, busy}, 32'd0);
        chk("rstmid.stage_start", {24'd0, stage_start}, 32'd0);
        chk("rstmid.fsm_state", {29'd0, fsm_state}, 32'd0);
        chk("rstmid.beat_addr", beat_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid.stays_idle", {29'd0, fsm_state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cg_iteration_sequencer.md
Name: cg_iteration_sequencer

Overview:
- Parametrised iteration controller for the complex (Bi)CG solver datapath.
- Replaces the ad-hoc per-stage flag chains with a single FSM that sequences the datapath sub-units through one iteration: dot products, mat-vec, divisions and vector updates.
- Issues vector-memory read beats, checks convergence against a runtime tolerance and bounds the iteration count.
- Sits between the top-level solver control and the sub-unit start/finish pins.

Parameters:
- NUM_EQ, 10, equations per cluster (vector length).
- NUM_LANES, 8, elements per memory beat.
- ITER_W, 16, width of iteration counter and max_iter.
- BEAT_MASK, 8'b0010_0001, stages that require read beats (bit s = stage s).
- CYC_W, 32, width of cycle counter (optional feature).
- Derived: NUM_BEATS = (NUM_EQ+NUM_LANES-1)/NUM_LANES; default 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  start-solve pulse; ignored while busy.
- abort  in  1  abandon solve.
- tol  in  32  tolerance, IEEE-754 single, compared against the real part of the residual norm.
- max_iter  in  ITER_W  iteration limit.
- stage_done  in  8  per-stage finish pulse from sub-units.
- rnorm_re  in  32  real part of the residual norm, valid with stage_done[5].
- stage_start  out  8  one-hot one-cycle start pulse per stage.
- read_beat  out  1  vector-memory read strobe (outsider read).
- beat_addr  out  32  beat index.
- busy  out  1  solve in progress.
- done  out  1  one-cycle end-of-solve pulse.
- converged  out  1  solve ended on tolerance.
- timeout  out  1  solve ended on max_iter.
- aborted  out  1  solve ended on abort.
- iter_count  out  ITER_W  completed iterations.
- fsm_state  out  3  current state encoding.
- cycle_count  out  CYC_W  cycles spent busy.

Behaviour:
- Stage indices:
  - 0 RHO (r·r), 1 MATVEC (A·p), 2 PAP (p·Ap), 3 ALPHA div.
  - 4 UPDATE_XR, 5 RNORM, 6 BETA div, 7 UPDATE_P.
- FSM states:
  - IDLE=0, ISSUE=1, BEATS=2, WAIT=3, CHECK=4, FINISH=5.
- Reset (async):
  - state IDLE; cur_stage 0.
  - All outputs 0; rnorm latch 0.
- IDLE:
  - On go: clear converged/timeout/aborted, iter_count, cycle_count; cur_stage=0; go to ISSUE.
- ISSUE:
  - stage_start[cur_stage]=1 for exactly one cycle.
  - Next state is BEATS if BEAT_MASK[cur_stage], else WAIT.
- BEATS:
  - read_beat=1 for NUM_BEATS consecutive cycles, beat_addr 0..NUM_BEATS-1; then WAIT.
  - beat_addr returns to 0 and read_beat to 0 outside BEATS.
- WAIT:
  - Leaves on stage_done[cur_stage].
  - A stage_done[cur_stage] arriving during BEATS is latched sticky and honoured on entry to WAIT.
  - stage_done bits of other stages are ignored.
  - Stage 5 done latches rnorm_re → CHECK.
  - Stage 7 done: cur_stage=1 → ISSUE; next iteration starts at MATVEC (rho reused from RNORM).
  - Any other stage: cur_stage+1 → ISSUE.
- CHECK (one cycle):
  - iter_count+1.
  - If rnorm ≤ tol (unsigned 32-bit compare, valid for non-negative floats; rnorm with sign bit set never converges): converged=1 → FINISH.
  - Else if new iter_count ≥ max_iter: timeout=1 → FINISH. max_iter 0 behaves as 1.
  - Else cur_stage=6 → ISSUE.
- FINISH:
  - done=1 for one cycle → IDLE.
  - converged/timeout/iter_count hold until next go.
- busy=1 in every state except IDLE.
- Latency per stage: 1 (ISSUE) + NUM_BEATS if masked + wait; CHECK adds 1 cycle.
- abort (any non-IDLE state):
  - Next state IDLE, aborted=1, no done pulse.
  - stage_start and read_beat deasserted the same edge.
  - abort has priority over go and stage_done in the same cycle.
- go concurrent with FINISH is ignored; a new go is accepted from IDLE only.

Optional Feature:
- Macro CG_SEQ_CYCLE_COUNT_EN.
- Defined: cycle_count increments every clock while busy, saturating at all-ones, cleared on go, and holds after the solve ends.
- Undefined: cycle_count is constant 0 and no counter is synthesised.

Test Plan:
- Convergence, 1 iteration: go, max_iter=5, each stage_done 3 cycles after its start, rnorm_re=0x3A000000, tol=0x3C23D70A → stage_start order 0,1,2,3,4,5; read_beat 2 cycles after stages 0 and 5; done pulse; converged=1; iter_count=1.
- Timeout: rnorm_re=0x3F800000, tol=0x3A83126F, max_iter=3 → stage order 0,1..5,6,7,1..5,6,7,1..5; timeout=1; iter_count=3; stage 0 issued once only.
- Early done: stage_done[0] asserted during beat 0 → latched; WAIT exits on its first cycle; stage 1 starts one cycle later.
- Abort: abort asserted in stage 2 WAIT → next cycle busy=0, aborted=1, done=0; a following go restarts with iter_count=0.
- Reset mid-solve: reset pulsed asynchronously in BEATS → read_beat, busy, stage_start drop immediately; fsm_state=0.
- Macro enabled: 1-iteration solve with 3-cycle waits → cycle_count equals busy-cycle count (30); macro disabled → cycle_count=0.
